// File: rtl/pattern_det_pkg.sv
// Shared types for the "10110" serial pattern scanner:
// one-hot detector states, controller states and the target pattern.
package pattern_det_pkg;

    typedef enum logic [4:0] {
        DET_INIT  = 5'b00001,
        DET_S1    = 5'b00010,
        DET_S10   = 5'b00100,
        DET_S101  = 5'b01000,
        DET_S1011 = 5'b10000
    } det_state_t;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_SHIFT = 2'd1,
        CTRL_DONE  = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] PATTERN = 5'b10110;

endpackage

// File: rtl/bit_pattern_fsm.sv
// Mealy detector for the serial "10110" pattern. Advances only while en is high;
// clear restarts it at Init, otherwise its state survives between words.
module bit_pattern_fsm
    import pattern_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_in,
    input  logic overlap,
    input  logic clear,
    output logic match
);

    det_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DET_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match   = 1'b0;
        if (clear) begin
            state_d = DET_INIT;
        end else if (en) begin
            case (state_q)
                DET_INIT:  state_d = bit_in ? DET_S1    : DET_INIT;
                DET_S1:    state_d = bit_in ? DET_S1    : DET_S10;
                DET_S10:   state_d = bit_in ? DET_S101  : DET_INIT;
                DET_S101:  state_d = bit_in ? DET_S1011 : DET_S10;
                DET_S1011: begin
                    if (bit_in) begin
                        state_d = DET_S1;
                    end else begin
                        // Overlapping mode keeps the trailing "10" as a fresh prefix.
                        match   = 1'b1;
                        state_d = overlap ? DET_S10 : DET_INIT;
                    end
                end
                default:   state_d = DET_INIT;
            endcase
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word sequencer: accepts words over valid/ready, shifts them MSB-first into the
// pattern detector and counts matches per word, pulsing done when the word is finished.
module pattern_scan_ctrl
    import pattern_det_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic [WIDTH-1:0] word_data,
    input  logic             overlap,
    input  logic             chain,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pulse_q;
    logic             accept;
    logic             shift_en;
    logic             det_match;

    bit_pattern_fsm u_det (
        .clk     (clk),
        .rst     (rst),
        .en      (shift_en),
        .bit_in  (shreg_q[WIDTH-1]),
        .overlap (overlap_q),
        .clear   (accept && !chain),
        .match   (det_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CTRL_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            overlap_q <= 1'b0;
            count_q   <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            overlap_q <= overlap_d;
            count_q   <= count_d;
            pulse_q   <= det_match;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        overlap_d  = overlap_q;
        count_d    = count_q;
        word_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        shift_en   = 1'b0;
        case (state_q)
            CTRL_IDLE: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    accept    = 1'b1;
                    shreg_d   = word_data;
                    bitcnt_d  = BCW'(WIDTH - 1);
                    overlap_d = overlap;
                    count_d   = '0;
                    state_d   = CTRL_SHIFT;
                end
            end
            CTRL_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                bitcnt_d = bitcnt_q - BCW'(1);
                if (bitcnt_q == '0) begin
                    state_d = CTRL_DONE;
                end
            end
            CTRL_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = CTRL_IDLE;
            end
            default: state_d = CTRL_IDLE;
        endcase
        // Matches only occur in SHIFT, so this never collides with the clear on accept.
        if (det_match && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign match_pulse = pulse_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed scenarios plus random words,
// checked against a sliding-window pattern model.
module tb_pattern_scan_ctrl;
    import pattern_det_pkg::*;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int W2  = 16;
    localparam int CW2 = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          word_valid;
    logic          word_ready;
    logic [W-1:0]  word_data;
    logic          overlap;
    logic          chain;
    logic          busy;
    logic          match_pulse;
    logic [CW-1:0] match_count;
    logic          done;

    logic           sValid;
    logic           sReady;
    logic [W2-1:0]  sData;
    logic           sOverlap;
    logic           sChain;
    logic           sBusy;
    logic           sPulse;
    logic [CW2-1:0] sCount;
    logic           sDone;

    int checks = 0;
    int errors = 0;

    logic [4:0] hist;
    int         histLen;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .overlap     (overlap),
        .chain       (chain),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .done        (done)
    );

    pattern_scan_ctrl #(.WIDTH(W2), .CNT_W(CW2)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .word_valid  (sValid),
        .word_ready  (sReady),
        .word_data   (sData),
        .overlap     (sOverlap),
        .chain       (sChain),
        .busy        (sBusy),
        .match_pulse (sPulse),
        .match_count (sCount),
        .done        (sDone)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: a match is the last five bits seen equalling PATTERN; non-overlapping
    // mode forgets the history after each match.
    function automatic bit modelBit(input bit b, input bit ov);
        hist = {hist[3:0], b};
        if (histLen < 5) histLen++;
        if (histLen >= 5 && hist == PATTERN) begin
            if (!ov) histLen = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic applyStimulus(input logic [W-1:0] data, input bit ov, input bit ch,
                                 input bit holdValid);
        int expPulse[W+2];
        int expCount[W+2];
        int cnt;
        bit m;
        word_data  = data;
        overlap    = ov;
        chain      = ch;
        word_valid = 1'b1;
        checkOutput("ready_idle", word_ready, 1);
        if (!ch) histLen = 0;
        cnt = 0;
        expPulse[1] = 0;
        expCount[1] = 0;
        for (int j = 1; j <= W; j++) begin
            m = modelBit(data[W-j], ov);
            if (m && cnt < (1 << CW) - 1) cnt++;
            expPulse[j+1] = int'(m);
            expCount[j+1] = cnt;
        end
        @(posedge clk); #1;
        if (!holdValid) begin
            word_valid = 1'b0;
        end else begin
            word_data = W'($urandom);
            overlap   = ~ov;
            chain     = ~ch;
        end
        for (int c = 1; c <= W + 1; c++) begin
            checkOutput("busy", busy, 1);
            checkOutput("ready_scan", word_ready, 0);
            checkOutput("done", done, int'(c == W + 1));
            checkOutput("pulse", match_pulse, expPulse[c]);
            checkOutput("count", match_count, expCount[c]);
            @(posedge clk); #1;
        end
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_pulse", match_pulse, 0);
        checkOutput("final_count", match_count, cnt);
    endtask

    task automatic resetMidScan();
        word_data  = 8'hB5;
        overlap    = 1'b0;
        chain      = 1'b0;
        word_valid = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        histLen = 0;
        checkOutput("rst_ready", word_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", match_count, 0);
        checkOutput("rst_pulse", match_pulse, 0);
        for (int c = 0; c < W + 2; c++) begin
            checkOutput("rst_no_done", done, 0);
            @(posedge clk); #1;
        end
        applyStimulus(8'h80, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_then_chain", match_count, 0);
    endtask

    task automatic saturationTest();
        int pulses;
        int dones;
        sData    = 16'hB6DB;
        sOverlap = 1'b1;
        sChain   = 1'b0;
        sValid   = 1'b1;
        checkOutput("sat_ready", sReady, 1);
        @(posedge clk); #1;
        sValid = 1'b0;
        pulses = 0;
        dones  = 0;
        for (int c = 1; c <= W2 + 1; c++) begin
            checkOutput("sat_busy", sBusy, 1);
            pulses += int'(sPulse);
            dones  += int'(sDone);
            @(posedge clk); #1;
        end
        checkOutput("sat_pulses", pulses, 4);
        checkOutput("sat_dones", dones, 1);
        checkOutput("sat_count", sCount, 3);
    endtask

    initial begin
        rst        = 1'b1;
        word_valid = 1'b0;
        word_data  = '0;
        overlap    = 1'b0;
        chain      = 1'b0;
        sValid     = 1'b0;
        sData      = '0;
        sOverlap   = 1'b0;
        sChain     = 1'b0;
        hist       = '0;
        histLen    = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", word_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pulse", match_pulse, 0);
        checkOutput("reset_count", match_count, 0);
        checkOutput("reset_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(8'hB0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_count", match_count, 1);
        applyStimulus(8'hB6, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_overlap_count", match_count, 2);
        applyStimulus(8'hB6, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_nonoverlap_count", match_count, 1);

        applyStimulus(8'h05, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_chain_count", match_count, 1);
        applyStimulus(8'h05, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_nochain_count", match_count, 0);

        resetMidScan();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        word_valid = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            if (($urandom % 3) == 0) d[W-1 -: 5] = PATTERN;
            applyStimulus(d, 1'($urandom), 1'($urandom), 1'b0);
        end

        saturationTest();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
